alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Execute-stage controller sitting between the ALU control decoder (7-bit one-hot op) and the register writeback.
- Accepts one ALU operation per transaction over a valid/ready handshake.
- ADD/SUB/AND/OR/NOT complete in one cycle. SHL/SHR are sequenced one bit per cycle by an internal counter.
- Holds the result and flags until writeback accepts them, and drives busy so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 16, datapath width of operands and result.
- SHW, 4, width of shift-amount field (shift range 0..2^SHW-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  sequencer can accept a request.
- op  input  7  one-hot op: ADD=0000001, SUB=0000010, AND=0000100, OR=0001000, NOT=0010000, SHR=0100000, SHL=1000000.
- a  input  WIDTH  operand A (also the shift/NOT source).
- b  input  WIDTH  operand B.
- shamt  input  SHW  shift amount, used only for SHL/SHR.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  writeback accepts result.
- result  output  WIDTH  operation result.
- flags  output  3  {C,N,Z}.
- err  output  1  illegal op; qualified by out_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE; result=0, flags=0, err=0, out_valid=0, shift counter=0, accumulator=0. in_ready=1 once rst is high.
- States: IDLE, SHIFT, DONE, encoded 2-bit binary.
- in_ready=1 only in IDLE. Acceptance = in_valid & in_ready at a rising edge; a, b, op and shamt are sampled at that edge only.
- IDLE, accept of ADD/SUB/AND/OR/NOT: result and flags computed and registered at the accepting edge; next state DONE. Latency is 1 cycle (out_valid high in the cycle after acceptance).
- ADD: result=a+b mod 2^WIDTH; C=carry out of MSB.
- SUB: result=a-b mod 2^WIDTH; C=1 when a<b unsigned (borrow).
- AND, OR: bitwise; C=0.
- NOT: result=~a; b ignored; C=0.
- IDLE, accept of SHL/SHR with shamt=0: result=a, C=0, next state DONE (latency 1).
- IDLE, accept of SHL/SHR with shamt=s>0:
  - At the accepting edge: accumulator=a, count=s, next state SHIFT.
  - Each SHIFT edge: accumulator shifted one bit (SHL: left, zero-fill; SHR: logical right, zero-fill); C register takes the bit shifted out; count decrements.
  - When count reaches 0: result=accumulator, state DONE.
  - out_valid is high s+1 cycles after acceptance, i.e. s shift edges plus the accept edge.
- Illegal op (zero bits set or more than one bit set): result=0, flags=0, err=1, state DONE, latency 1.
- err is cleared on the next acceptance.
- N=result[WIDTH-1] and Z=(result==0) for every legal op. Both are registered together with result.
- DONE: out_valid=1. result, flags and err are held stable until out_ready=1.
  - out_valid & out_ready: next state IDLE, out_valid=0.
  - No new request is accepted in the same cycle, so maximum throughput is one op per 2 cycles.
  - result/flags retain their last value in IDLE. Consumers qualify them with out_valid.
- in_valid asserted while busy is ignored. The requester must hold the request until in_ready.
- SHIFT ignores in_valid, op and out_ready. Changing inputs mid-shift has no effect on the operation in flight.
- Reset asserted mid-SHIFT or in DONE: immediate return to the reset values; the in-flight result is discarded.
- Unused state encoding: next state IDLE, outputs at reset values.

Decomposition:
- Shared package alu_pkg holds:
  - the seven one-hot op constants (shared with the ALU control decoder);
  - the state encoding;
  - flag bit indices C=2, N=1, Z=0;
  - WIDTH and SHW defaults.
- One sub-module, alu_comb: purely combinational single-cycle ADD/SUB/AND/OR/NOT with carry/borrow out, instantiated once inside alu_op_sequencer.
- Shift sequencing, FSM, flag registration and handshake stay in the top module.

Test Plan:
- Reset then ADD a=0xFFFF, b=0x0001 -> out_valid 1 cycle after accept; result=0x0000, flags C=1 N=0 Z=1, err=0.
- SUB a=0x0003, b=0x0005 -> result=0xFFFE, C=1, N=1, Z=0; out_ready held low 3 cycles -> outputs stable, in_ready=0 and busy=1 throughout.
- SHL a=0x8001, shamt=3 -> busy for 3 SHIFT cycles; out_valid 4 cycles after accept; result=0x0008, C=0. SHR a=0x0003, shamt=1 -> result=0x0001, C=1.
- SHR a=0x1234, shamt=0 -> result=0x1234, C=0, latency 1. SHL shamt=15 on a=0x0001 -> result=0x8000, N=1, latency 16.
- op=0000011 (two bits set) -> err=1, result=0, flags=0. Next legal OR a=0x00F0, b=0x0F00 -> result=0x0FF0, err=0.
- rst driven low mid-SHIFT (shamt=10, after 4 cycles) -> out_valid=0, busy=0, result=0 immediately. After release, in_ready=1 and a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM states and flag layout shared by the ALU decoder and execute stage
package alu_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SHW = 4;
  localparam logic [6:0] OP_ADD = 7'b0000001;
  localparam logic [6:0] OP_SUB = 7'b0000010;
  localparam logic [6:0] OP_AND = 7'b0000100;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_NOT = 7'b0010000;
  localparam logic [6:0] OP_SHR = 7'b0100000;
  localparam logic [6:0] OP_SHL = 7'b1000000;
  localparam int FC = 2;
  localparam int FN = 1;
  localparam int FZ = 0;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;
  function automatic logic [2:0] mk_flags(input logic c, input logic n, input logic z);
    logic [2:0] f;
    f = '0;
    f[FC] = c;
    f[FN] = n;
    f[FZ] = z;
    return f;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request and writeback handshake bundle for the execute-stage sequencer
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SHW = 4
);
  logic in_valid;
  logic in_ready;
  logic [6:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0] shamt;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0] flags;
  logic err;
  logic busy;
  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, flags, err, busy
  );
  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, flags, err, busy
  );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ADD/SUB/AND/OR/NOT with carry (ADD) or borrow (SUB) out
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             c
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  assign sum = {1'b0, a} + {1'b0, b};
  // top bit of the widened difference is the unsigned borrow
  assign dif = {1'b0, a} - {1'b0, b};
  always_comb begin
    y = op == OP_ADD ? sum[WIDTH-1:0] :
        op == OP_SUB ? dif[WIDTH-1:0] :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_NOT ? ~a : '0;
    c = op == OP_ADD ? sum[WIDTH] :
        op == OP_SUB ? dif[WIDTH] : 1'b0;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: execute-stage controller issuing single-cycle ALU ops and bit-serial shifts
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW = DEF_SHW
) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, res_q, alu_y, acc_nx;
  logic [SHW-1:0] cnt_q;
  logic [2:0] flg_q;
  logic shl_q, err_q, alu_c, sh_out, accept, legal, is_shift, long_shift, last_shift, valid_st;
  assign valid_st = state_q inside {IDLE, SHIFT, DONE};
  assign accept = bus.in_valid && state_q == IDLE;
  assign legal = $onehot(bus.op);
  assign is_shift = bus.op == OP_SHL || bus.op == OP_SHR;
  assign long_shift = is_shift && bus.shamt != '0;
  assign last_shift = cnt_q == SHW'(1);
  assign acc_nx = shl_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
  assign sh_out = shl_q ? acc_q[WIDTH-1] : acc_q[0];
  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op(bus.op),
    .a (bus.a),
    .b (bus.b),
    .y (alu_y),
    .c (alu_c)
  );
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE : (legal && long_shift) ? SHIFT : DONE;
      SHIFT:   state_d = last_shift ? DONE : SHIFT;
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      shl_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else if (!valid_st) begin
      acc_q <= '0;
      cnt_q <= '0;
      shl_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= !legal;
      if (!legal) begin
        res_q <= '0;
        flg_q <= '0;
      end else if (long_shift) begin
        acc_q <= bus.a;
        cnt_q <= bus.shamt;
        shl_q <= bus.op == OP_SHL;
      end else if (is_shift) begin
        res_q <= bus.a;
        flg_q <= mk_flags(1'b0, bus.a[WIDTH-1], bus.a == '0);
      end else begin
        res_q <= alu_y;
        flg_q <= mk_flags(alu_c, alu_y[WIDTH-1], alu_y == '0);
      end
    end else if (state_q == SHIFT) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q - SHW'(1);
      // final shift edge writes the result directly so DONE follows with no extra cycle
      if (last_shift) begin
        res_q <= acc_nx;
        flg_q <= mk_flags(sh_out, acc_nx[WIDTH-1], acc_nx == '0);
      end
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q == SHIFT || state_q == DONE;
  assign bus.result = valid_st ? res_q : '0;
  assign bus.flags = valid_st ? flg_q : '0;
  assign bus.err = valid_st && err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for the ALU op sequencer
module tb_alu_op_sequencer;
  localparam int W = 16;
  localparam int S = 4;
  localparam logic [6:0] ADD = 7'b0000001;
  localparam logic [6:0] SUB = 7'b0000010;
  localparam logic [6:0] AND = 7'b0000100;
  localparam logic [6:0] OR  = 7'b0001000;
  localparam logic [6:0] NOT = 7'b0010000;
  localparam logic [6:0] SHR = 7'b0100000;
  localparam logic [6:0] SHL = 7'b1000000;
  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   flg;
    logic         err;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vecs = 0;
  int miss = 0;
  exp_t sbq[$];
  logic [6:0] ops[7] = '{ADD, SUB, AND, OR, NOT, SHR, SHL};
  alu_op_sequencer_if #(.WIDTH(W), .SHW(S)) bus ();
  alu_op_sequencer #(.WIDTH(W), .SHW(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [S-1:0] s);
    exp_t e;
    logic [W:0] t;
    logic c;
    int k;
    k = int'(s);
    c = 1'b0;
    e.err = 1'b0;
    e.lat = 1;
    e.res = '0;
    case (op)
      ADD: begin t = {1'b0, a} + {1'b0, b}; e.res = t[W-1:0]; c = t[W]; end
      SUB: begin e.res = a - b; c = a < b; end
      AND: e.res = a & b;
      OR:  e.res = a | b;
      NOT: e.res = ~a;
      SHR: begin e.res = a >> k; c = k == 0 ? 1'b0 : a[k-1]; e.lat = k + 1; end
      SHL: begin e.res = a << k; c = k == 0 ? 1'b0 : a[W-k]; e.lat = k + 1; end
      default: e.err = 1'b1;
    endcase
    e.flg = e.err ? 3'b000 : {c, e.res[W-1], e.res == '0};
    return e;
  endfunction
  task automatic issue(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [S-1:0] s, input bit track);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.shamt = s;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    if (track) sbq.push_back(model(op, a, b, s));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op = 7'($urandom);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.shamt = S'($urandom);
  endtask
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk({tag, "_busy"}, {30'd0, bus.busy, bus.in_ready}, 32'd2);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_sb_depth"}, sbq.size(), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_result"}, {16'd0, bus.result}, {16'd0, e.res});
      chk({tag, "_flags"}, {29'd0, bus.flags}, {29'd0, e.flg});
      chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
      repeat (hold) begin
        bus.in_valid = 1'b1;
        bus.op = ADD;
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {bus.out_valid, bus.busy, bus.in_ready, bus.err, bus.flags, bus.result},
            {1'b1, 1'b1, 1'b0, e.err, e.flg, e.res});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_release"}, {bus.out_valid, bus.busy, bus.in_ready, bus.result},
          {1'b0, 1'b0, 1'b1, e.res});
    end else begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.shamt = '0;
    #12;
    chk("reset_state", {bus.out_valid, bus.busy, bus.err, bus.flags, bus.result}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue(ADD, 16'hFFFF, 16'h0001, 4'd0, 1'b1);
    collect("add_wrap", 0);
    issue(SUB, 16'h0003, 16'h0005, 4'd0, 1'b1);
    collect("sub_borrow", 3);
    issue(SHL, 16'h8001, 16'h0000, 4'd3, 1'b1);
    collect("shl3", 0);
    issue(SHR, 16'h0003, 16'h0000, 4'd1, 1'b1);
    collect("shr1", 0);
    issue(SHR, 16'h1234, 16'h0000, 4'd0, 1'b1);
    collect("shr0", 0);
    issue(SHL, 16'h0001, 16'h0000, 4'd15, 1'b1);
    collect("shl15", 0);
    issue(7'b0000011, 16'h5555, 16'hAAAA, 4'd0, 1'b1);
    collect("illegal_two", 0);
    issue(OR, 16'h00F0, 16'h0F00, 4'd0, 1'b1);
    collect("or_after_err", 0);
    issue(AND, 16'hF0F0, 16'h3C3C, 4'd0, 1'b1);
    collect("and", 0);
    issue(NOT, 16'h00FF, 16'h1234, 4'd0, 1'b1);
    collect("not", 0);
    issue(ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b1);
    collect("add_neg", 0);
    issue(SUB, 16'h0005, 16'h0005, 4'd0, 1'b1);
    collect("sub_zero", 0);
    issue(7'b0000000, 16'h1111, 16'h2222, 4'd0, 1'b1);
    collect("illegal_zero", 0);
    issue(SHR, 16'h8000, 16'h0000, 4'd15, 1'b1);
    collect("shr15", 1);
    issue(SHL, 16'hC000, 16'h0000, 4'd2, 1'b1);
    collect("shl_out", 0);
    for (int i = 0; i < 8; i++) begin
      issue(ops[$urandom_range(0, 6)], W'($urandom), W'($urandom), S'($urandom), 1'b1);
      collect("random", i % 2);
    end
    issue(SHL, 16'h0001, 16'h0000, 4'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_shift_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_shift", {bus.out_valid, bus.busy, bus.err, bus.flags, bus.result}, 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    issue(ADD, 16'h1234, 16'h1111, 4'd0, 1'b1);
    collect("add_after_rst", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
